// File: rtl/exec_div_pkg.sv
// exec_div shared definitions: iFunc bits, FSM states, quotient limits.
// EXEC_DIV_MINQ_EN: allow the most-negative signed quotient (80186 rule).
package exec_div_pkg;

  localparam int FUNC_WIDTH_BIT  = 0;
  localparam int FUNC_SIGNED_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic [31:0] QLIM_U_B = 32'h0000_00FF;
  localparam logic [31:0] QLIM_U_W = 32'h0000_FFFF;
  localparam logic [31:0] QLIM_P_B = 32'h0000_007F;
  localparam logic [31:0] QLIM_P_W = 32'h0000_7FFF;
`ifdef EXEC_DIV_MINQ_EN
  localparam logic [31:0] QLIM_N_B = 32'h0000_0080;
  localparam logic [31:0] QLIM_N_W = 32'h0000_8000;
`else
  localparam logic [31:0] QLIM_N_B = 32'h0000_007F;
  localparam logic [31:0] QLIM_N_W = 32'h0000_7FFF;
`endif

endpackage

// File: rtl/exec_div_neg.sv
// Conditional two's-complement negator, width W.
// Used for operand magnitudes and the final sign fix-up.
module exec_div_neg #(
  parameter int W = 16
) (
  input  logic         iNeg,
  input  logic [W-1:0] iVal,
  output logic [W-1:0] oVal
);

  assign oVal = iNeg ? ((~iVal) + W'(1)) : iVal;

endmodule

// File: rtl/exec_div.sv
// DIV/IDIV restoring divider, one quotient bit per clock.
// EXEC_DIV_MINQ_EN (see exec_div_pkg) relaxes the negative quotient limit.
module exec_div
  import exec_div_pkg::*;
(
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iStart,
  input  logic [3:0]  iFunc,
  input  logic [15:0] R1,
  input  logic [15:0] R2,
  input  logic [15:0] R3,
  output logic [15:0] oQuot,
  output logic [15:0] oRem,
  output logic        oBusy,
  output logic        oDone,
  output logic        oDivErr
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] q_q, q_d;
  logic [15:0] r_q, r_d;
  logic [15:0] dvs_q, dvs_d;
  logic        wide_q, wide_d;
  logic        sgn_q, sgn_d;
  logic        sd_q, sd_d;
  logic        sv_q, sv_d;
  logic        dz_q, dz_d;
  logic [15:0] quot_q, quot_d;
  logic [15:0] rem_q, rem_d;
  logic        err_q, err_d;

  logic        wide_in, sgn_in;
  logic [31:0] dvd_raw, dvd_mag;
  logic [15:0] dvs_raw, dvs_mag;
  logic        dvd_neg, dvs_neg;
  logic        q_neg;
  logic [15:0] q_fix, r_fix;
  logic        unused_func;

  assign unused_func = ^iFunc[3:2];
  assign wide_in = iFunc[FUNC_WIDTH_BIT];
  assign sgn_in  = iFunc[FUNC_SIGNED_BIT];

  // Sign-extend operands to their working widths and pick their signs
  always_comb begin
    dvd_raw = wide_in ? {R2, R1} : {{16{R1[15] & sgn_in}}, R1};
    dvs_raw = wide_in ? R3 : {{8{R3[7] & sgn_in}}, R3[7:0]};
    dvd_neg = sgn_in & (wide_in ? R2[15] : R1[15]);
    dvs_neg = sgn_in & (wide_in ? R3[15] : R3[7]);
  end

  assign q_neg = sgn_q & (sd_q ^ sv_q);

  exec_div_neg #(.W(32)) u_neg_dvd (
    .iNeg(dvd_neg), .iVal(dvd_raw), .oVal(dvd_mag)
  );
  exec_div_neg #(.W(16)) u_neg_dvs (
    .iNeg(dvs_neg), .iVal(dvs_raw), .oVal(dvs_mag)
  );
  exec_div_neg #(.W(16)) u_neg_quot (
    .iNeg(q_neg), .iVal(q_q[15:0]), .oVal(q_fix)
  );
  exec_div_neg #(.W(16)) u_neg_rem (
    .iNeg(sgn_q & sd_q), .iVal(r_q), .oVal(r_fix)
  );

  // Next-state, datapath iteration and result fix-up
  always_comb begin
    logic [16:0] trial;
    logic [16:0] diff;
    logic        ge;
    logic [31:0] lim;
    logic        err;
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    wide_d  = wide_q;
    sgn_d   = sgn_q;
    sd_d    = sd_q;
    sv_d    = sv_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    trial   = {r_q, q_q[31]};
    diff    = trial - {1'b0, dvs_q};
    ge      = (trial >= {1'b0, dvs_q});
    lim     = 32'h0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          // Byte dividends are left-aligned so bit 31 always feeds in
          q_d    = wide_in ? dvd_mag : {dvd_mag[15:0], 16'h0000};
          r_d    = 16'h0000;
          dvs_d  = dvs_mag;
          wide_d = wide_in;
          sgn_d  = sgn_in;
          sd_d   = dvd_neg;
          sv_d   = dvs_neg;
          dz_d   = (dvs_raw == 16'h0000);
          cnt_d  = wide_in ? 6'd32 : 6'd16;
          state_d = (dvs_raw == 16'h0000) ? FIX : CALC;
        end
      end
      CALC: begin
        r_d   = ge ? diff[15:0] : trial[15:0];
        q_d   = {q_q[30:0], ge};
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = FIX;
      end
      FIX: begin
        unique case (1'b1)
          !sgn_q: lim = wide_q ? QLIM_U_W : QLIM_U_B;
          q_neg:  lim = wide_q ? QLIM_N_W : QLIM_N_B;
          default: lim = wide_q ? QLIM_P_W : QLIM_P_B;
        endcase
        err    = dz_q | (q_q > lim);
        err_d  = err;
        quot_d = err ? 16'h0000 :
                 wide_q ? q_fix : {8'h00, q_fix[7:0]};
        rem_d  = err ? 16'h0000 :
                 wide_q ? r_fix : {8'h00, r_fix[7:0]};
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      q_q     <= 32'h0;
      r_q     <= 16'h0;
      dvs_q   <= 16'h0;
      wide_q  <= 1'b0;
      sgn_q   <= 1'b0;
      sd_q    <= 1'b0;
      sv_q    <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= 16'h0;
      rem_q   <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      wide_q  <= wide_d;
      sgn_q   <= sgn_d;
      sd_q    <= sd_d;
      sv_q    <= sv_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign oQuot   = quot_q;
  assign oRem    = rem_q;
  assign oDivErr = err_q;
  assign oBusy   = (state_q == CALC) || (state_q == FIX);
  assign oDone   = (state_q == DONE);

endmodule
